// File: rtl/fetch_redirect_controller.sv
// Fetch PC sequencer: chooses trap, mispredict, held redirect, prediction or PC+4 and flushes decode/execute.
// Optional macro FETCH_MISALIGN_CHECK_EN rejects misaligned targets instead of masking their low bits.
module fetch_redirect_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          ALIGN_BITS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_fetch,
    input  logic        imem_ready,
    input  logic        trap_req,
    input  logic [31:0] trap_target,
    input  logic        mispredict_req,
    input  logic [31:0] mispredict_target,
    input  logic        predict_valid,
    input  logic [31:0] predict_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        clear_decoding_stage,
    output logic        clear_execution_stage,
    output logic        redirect_pending,
    output logic        fetch_misaligned,
    output logic [1:0]  state
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);

    logic [31:0] pend_target;
    logic        pend_trap;

    logic        new_req;
    logic        take_pend;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        redir_is_trap;
    logic        redir_bad;
    logic        pred_bad;
    logic [31:0] redir_use;
    logic [31:0] pred_use;

    // Handshake: a fetch is offered whenever pc_valid=1 and completes on a cycle with imem_ready=1;
    // pc only moves on such a cycle (or never, while a redirect is held in WAIT).
    assign pc_valid              = (state != BOOT);
    assign clear_decoding_stage  = ~rst & (trap_req | mispredict_req);
    assign clear_execution_stage = ~rst & (trap_req | mispredict_req);

    always_comb begin
        new_req       = trap_req | mispredict_req;
        // A held trap outranks a fresh mispredict; a fresh trap outranks anything held.
        take_pend     = redirect_pending && (pend_trap ? !trap_req : !new_req);
        redir_valid   = new_req | redirect_pending;
        redir_target  = take_pend ? pend_target : (trap_req ? trap_target : mispredict_target);
        redir_is_trap = take_pend ? pend_trap : trap_req;
`ifdef FETCH_MISALIGN_CHECK_EN
        redir_bad     = |(redir_target & ~ALIGN_MASK);
        pred_bad      = |(predict_target & ~ALIGN_MASK);
        redir_use     = redir_target;
        pred_use      = predict_target;
`else
        redir_bad     = 1'b0;
        pred_bad      = 1'b0;
        redir_use     = redir_target & ALIGN_MASK;
        pred_use      = predict_target & ALIGN_MASK;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc               <= RESET_VECTOR;
            state            <= BOOT;
            redirect_pending <= 1'b0;
            pend_target      <= 32'd0;
            pend_trap        <= 1'b0;
            fetch_misaligned <= 1'b0;
        end else begin
            fetch_misaligned <= 1'b0;
            if (redir_valid) begin
                if (redir_bad) begin
                    fetch_misaligned <= 1'b1;
                    redirect_pending <= 1'b0;
                    state            <= RUN;
                end else if (imem_ready) begin
                    pc               <= redir_use;
                    redirect_pending <= 1'b0;
                    state            <= RUN;
                end else begin
                    pend_target      <= redir_target;
                    pend_trap        <= redir_is_trap;
                    redirect_pending <= 1'b1;
                    state            <= WAIT;
                end
            end else if (state == BOOT) begin
                state <= RUN;
            end else if (state == RUN && imem_ready && !stall_fetch) begin
                if (predict_valid && pred_bad) begin
                    fetch_misaligned <= 1'b1;
                end else if (predict_valid) begin
                    pc <= pred_use;
                end else begin
                    pc <= pc + 32'd4;
                end
            end
        end
    end

endmodule
